// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: streams a host program image into the shared memory, then
// releases the CPU and hands it the memory bus until halt, timeout or abort.
module boot_loader_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int MAX_RUN = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_start,
    input  logic              host_abort,
    input  logic [ADDR_W:0]   host_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_wdata,
    input  logic              cpu_mem_wr,
    input  logic              cpu_halt,
    output logic              cpu_reset_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   load_count
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [15:0]       RUN_LAST = 16'(MAX_RUN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   load_count_q;
    logic [ADDR_W:0]   len_q;
    logic [15:0]       run_cnt_q;

    logic [ADDR_W:0]   len_d;
    logic              xfer;
    logic              last_word;

    // Requests longer than the memory simply fill it once.
    assign len_d      = (host_len > DEPTH) ? DEPTH : host_len;
    assign host_ready = (state_q == S_LOAD);
    assign xfer       = host_ready && host_valid;
    assign last_word  = (load_count_q == (len_q - CNT_ONE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            len_q        <= '0;
            run_cnt_q    <= '0;
        end else begin
            // A word presented on the abort cycle is still written and counted.
            if (xfer) begin
                wr_ptr_q     <= wr_ptr_q + PTR_ONE;
                load_count_q <= load_count_q + CNT_ONE;
            end
            if (host_abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE, S_HALTED, S_TIMEOUT: begin
                        if (host_start) begin
                            len_q        <= len_d;
                            wr_ptr_q     <= '0;
                            load_count_q <= '0;
                            state_q      <= (host_len == '0) ? S_RELEASE : S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (xfer && last_word) state_q <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        run_cnt_q <= '0;
                        state_q   <= S_RUN;
                    end
                    S_RUN: begin
                        run_cnt_q <= run_cnt_q + 16'd1;
                        if (cpu_halt)                    state_q <= S_HALTED;
                        else if (run_cnt_q == RUN_LAST)  state_q <= S_TIMEOUT;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
    assign done        = (state_q == S_HALTED);
    assign timeout     = (state_q == S_TIMEOUT);
    assign cpu_reset_n = (state_q == S_RUN) || (state_q == S_HALTED);
    assign load_count  = load_count_q;

    // Bus ownership: loader in LOAD, CPU in RUN/HALTED, nobody otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        case (state_q)
            S_LOAD: begin
                mem_addr  = wr_ptr_q;
                mem_wdata = host_data;
                mem_wr    = host_valid;
            end
            S_RUN, S_HALTED: begin
                mem_addr  = cpu_mem_addr;
                mem_wdata = cpu_mem_wdata;
                mem_wr    = cpu_mem_wr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed scenarios plus random traffic, checked
// every cycle against a phase/count model and a memory-write scoreboard.
module tb_boot_loader_ctrl;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int MAXR = 8;
    localparam int DEPTH = 1 << AW;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RELEASE = 2, M_RUN = 3, M_HALTED = 4, M_TIMEOUT = 5;

    logic          clock, reset, host_start, host_abort, host_valid, host_ready;
    logic [AW:0]   host_len, load_count;
    logic [DW-1:0] host_data, cpu_mem_wdata, mem_wdata;
    logic [AW-1:0] cpu_mem_addr, mem_addr;
    logic          cpu_mem_wr, cpu_halt, cpu_reset_n, mem_wr, busy, done, timeout;

    boot_loader_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_RUN(MAXR)) dut (
        .clock(clock), .reset(reset), .host_start(host_start), .host_abort(host_abort),
        .host_len(host_len), .host_valid(host_valid), .host_data(host_data),
        .host_ready(host_ready), .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wr(cpu_mem_wr), .cpu_halt(cpu_halt), .cpu_reset_n(cpu_reset_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .busy(busy),
        .done(done), .timeout(timeout), .load_count(load_count)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // model: current phase, words requested, words written, RUN cycles elapsed
    int m_mode, m_len, m_loaded, m_runs;
    logic [DW-1:0]    exp_mem [DEPTH];
    logic [DW-1:0]    seen_mem[DEPTH];
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        logic e_load, e_cpu, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        logic [AW+DW-1:0] front;
        e_load = (m_mode == M_LOAD);
        e_cpu  = (m_mode == M_RUN) || (m_mode == M_HALTED);
        e_wr = 1'b0; e_addr = '0; e_data = '0;
        if (e_load) begin
            e_wr = host_valid; e_addr = m_loaded[AW-1:0]; e_data = host_data;
        end else if (e_cpu) begin
            e_wr = cpu_mem_wr; e_addr = cpu_mem_addr; e_data = cpu_mem_wdata;
        end
        chk("host_ready", host_ready, e_load);
        chk("busy", busy, (m_mode == M_LOAD) || (m_mode == M_RELEASE) || (m_mode == M_RUN));
        chk("done", done, m_mode == M_HALTED);
        chk("timeout", timeout, m_mode == M_TIMEOUT);
        chk("cpu_reset_n", cpu_reset_n, e_cpu);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("load_count", load_count, m_loaded[AW:0]);
        if (e_wr || e_cpu) chk("mem_wdata", mem_wdata, e_data);
        if (e_wr) exp_q.push_back({e_addr, e_data});
        if (mem_wr === 1'b1) begin
            seen_mem[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL write_sb: got write 0x%0h@0x%0h, expected no write", mem_wdata, mem_addr);
            end else begin
                front = exp_q.pop_front();
                chk("write_sb", {mem_addr, mem_wdata}, front);
            end
        end
    endtask

    task automatic model_step();
        // memory sees the bus regardless of what the sequencer does next
        if (m_mode == M_LOAD && host_valid) exp_mem[m_loaded[AW-1:0]] = host_data;
        if ((m_mode == M_RUN || m_mode == M_HALTED) && cpu_mem_wr) exp_mem[cpu_mem_addr] = cpu_mem_wdata;
        if (reset) begin
            m_mode = M_IDLE; m_len = 0; m_loaded = 0; m_runs = 0;
        end else begin
            if (m_mode == M_LOAD && host_valid) m_loaded++;
            if (host_abort && m_mode != M_IDLE) begin
                m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE, M_HALTED, M_TIMEOUT: begin
                        if (host_start) begin
                            m_len    = (int'(host_len) > DEPTH) ? DEPTH : int'(host_len);
                            m_loaded = 0;
                            m_mode   = (m_len == 0) ? M_RELEASE : M_LOAD;
                        end
                    end
                    M_LOAD:    if (m_loaded == m_len) m_mode = M_RELEASE;
                    M_RELEASE: begin m_runs = 0; m_mode = M_RUN; end
                    M_RUN: begin
                        m_runs++;
                        if (cpu_halt)            m_mode = M_HALTED;
                        else if (m_runs == MAXR) m_mode = M_TIMEOUT;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        check();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic check_image(input string name);
        for (int i = 0; i < DEPTH; i++) chk(name, seen_mem[i], exp_mem[i]);
    endtask

    initial begin
        host_start = 0; host_abort = 0; host_len = '0; host_valid = 0; host_data = '0;
        cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_wr = 0; cpu_halt = 0;
        m_mode = M_IDLE; m_len = 0; m_loaded = 0; m_runs = 0;
        for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = '0; seen_mem[i] = '0; end

        reset = 1;
        @(posedge clock); model_step(); #1;
        cycle();
        reset = 0;
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_mem_wr", mem_wr, 0);

        // three-word load with continuous valid
        host_len = 6'd3; host_start = 1; cycle(); host_start = 0;
        host_valid = 1;
        host_data = 8'h21; cycle();
        host_data = 8'h45; cycle();
        host_data = 8'hE0; cycle();
        host_valid = 0;
        chk("t1_release_busy", busy, 1);
        chk("t1_release_cpu_reset_n", cpu_reset_n, 0);
        chk("t1_load_count", load_count, 3);
        chk("t1_ready_drop", host_ready, 0);
        cycle();
        chk("t1_run_cpu_reset_n", cpu_reset_n, 1);
        chk("t1_word0", seen_mem[0], 8'h21);
        chk("t1_word1", seen_mem[1], 8'h45);
        chk("t1_word2", seen_mem[2], 8'hE0);

        // CPU write passes straight through, then halt on 4th RUN cycle
        cpu_mem_wr = 1; cpu_mem_addr = 5'h1F; cpu_mem_wdata = 8'h7A; #1;
        chk("t3_mem_wr", mem_wr, 1);
        chk("t3_mem_addr", mem_addr, 5'h1F);
        chk("t3_mem_wdata", mem_wdata, 8'h7A);
        cycle(); cpu_mem_wr = 0;
        cycle(); cycle();
        cpu_halt = 1; cycle(); cpu_halt = 0;
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_cpu_reset_n", cpu_reset_n, 1);
        chk("t3_mem_1f", seen_mem[31], 8'h7A);

        // zero-length restart from HALTED; start during RUN ignored; timeout
        host_len = '0; host_start = 1; cycle(); host_start = 0;
        chk("t5_release_busy", busy, 1);
        chk("t5_release_cpu_reset_n", cpu_reset_n, 0);
        cycle();
        host_len = 6'd3; host_start = 1; cycle(); host_start = 0;
        chk("t5_start_ignored", cpu_reset_n, 1);
        repeat (7) cycle();
        chk("t4_timeout", timeout, 1);
        chk("t4_cpu_reset_n", cpu_reset_n, 0);
        chk("t4_busy", busy, 0);

        // halt coincident with run limit
        host_len = '0; host_start = 1; cycle(); host_start = 0;
        cycle();
        repeat (7) cycle();
        cpu_halt = 1; cycle(); cpu_halt = 0;
        chk("t4_coincident_done", done, 1);
        chk("t4_coincident_timeout", timeout, 0);

        // abort after two words
        host_len = 6'd4; host_start = 1; cycle(); host_start = 0;
        host_valid = 1;
        host_data = 8'h11; cycle();
        host_data = 8'h22; cycle();
        host_valid = 0; host_abort = 1; cycle(); host_abort = 0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_count", load_count, 2);
        cycle();
        chk("t5_abort_count_hold", load_count, 2);

        // reset during second word of four
        host_len = 6'd4; host_start = 1; cycle(); host_start = 0;
        host_valid = 1; host_data = 8'h33; cycle();
        host_data = 8'h44; reset = 1; cycle(); reset = 0; host_valid = 0;
        chk("t6_rst_count", load_count, 0);
        chk("t6_rst_ready", host_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_mem_wr", mem_wr, 0);

        // oversize request clamps to a full memory
        host_len = 6'd40; host_start = 1; cycle(); host_start = 0;
        host_valid = 1;
        repeat (DEPTH) begin host_data = 8'($urandom_range(0, 255)); cycle(); end
        host_valid = 0;
        chk("t6_clamp_count", load_count, 32);
        chk("t6_clamp_release", host_ready, 0);
        check_image("mem_image_directed");

        // random traffic
        repeat (3000) begin
            reset      = ($urandom_range(0, 199) == 0);
            host_start = ($urandom_range(0, 7) == 0);
            host_abort = (m_mode != M_IDLE) && ($urandom_range(0, 59) == 0);
            host_len   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            host_valid = 1'($urandom_range(0, 1));
            host_data  = 8'($urandom_range(0, 255));
            cpu_mem_wr    = 1'($urandom_range(0, 1));
            cpu_mem_addr  = 5'($urandom_range(0, 31));
            cpu_mem_wdata = 8'($urandom_range(0, 255));
            cpu_halt   = ($urandom_range(0, 11) == 0);
            cycle();
        end
        reset = 0; host_start = 0; host_abort = 0; host_valid = 0; cpu_mem_wr = 0; cpu_halt = 0;
        check_image("mem_image_random");
        chk("write_sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
Sequencer that owns the single-port program/data memory of the simple processor and the processor's reset line. It loads a program from a host byte stream into memory, releases the control unit to run, and hands the memory bus to the CPU. It also watches for halt or a run-time overrun and reports status back to the host. It sits between the host interface, the memory and the processor core.

Parameters:
ADDR_W, 5, memory address width (2^ADDR_W words)
DATA_W, 8, memory word width (3-bit opcode + ADDR_W operand)
MAX_RUN, 1000, run-cycle limit before timeout (1..65535)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces IDLE
host_start  in  1  pulse: begin load/run sequence
host_abort  in  1  pulse: return to IDLE from any state
host_len  in  ADDR_W+1  words to load, sampled on accepted host_start; 0 = run existing image
host_valid  in  1  host word valid
host_data  in  DATA_W  host word
host_ready  out  1  loader accepts word this cycle
cpu_mem_addr  in  ADDR_W  CPU memory address
cpu_mem_wdata  in  DATA_W  CPU write data
cpu_mem_wr  in  1  CPU write strobe
cpu_halt  in  1  CPU halt flag
cpu_reset_n  out  1  active-low reset to control unit
mem_addr  out  ADDR_W  muxed memory address
mem_wdata  out  DATA_W  muxed write data
mem_wr  out  1  muxed write strobe
busy  out  1  state is LOAD, RELEASE or RUN
done  out  1  state is HALTED
timeout  out  1  state is TIMEOUT
load_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN, HALTED, TIMEOUT. Registered state; outputs decoded from state except the write-path mux.
- Reset: state=IDLE, wr_ptr=0, load_count=0, len_q=0, run_cnt=0, cpu_reset_n=0, host_ready=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=done=timeout=0. Memory contents untouched.
- IDLE: cpu_reset_n=0. host_start: len_q<=host_len, wr_ptr<=0, load_count<=0; next = LOAD if host_len!=0 else RELEASE.
- host_len > 2^ADDR_W is clamped to 2^ADDR_W.
- LOAD: host_ready=1, cpu_reset_n=0. Transfer when host_valid&host_ready: same cycle mem_wr=1, mem_addr=wr_ptr, mem_wdata=host_data; wr_ptr and load_count increment next edge. On the transfer where load_count==len_q-1 -> RELEASE. No transfer: mem_wr=0, mem_addr=wr_ptr.
- RELEASE: exactly one cycle, cpu_reset_n=0, mem_wr=0, run_cnt<=0; -> RUN.
- RUN: cpu_reset_n=1 (CPU's first active cycle is the first RUN cycle); mem_addr/mem_wdata/mem_wr = cpu_mem_* combinationally; run_cnt increments each cycle. cpu_halt=1 -> HALTED. Else run_cnt==MAX_RUN-1 -> TIMEOUT. Halt and limit in the same cycle: HALTED wins.
- HALTED: cpu_reset_n stays 1, memory bus stays with CPU (CPU idles in its halt state), done=1.
- TIMEOUT: cpu_reset_n=0, mem_wr=0, timeout=1.
- HALTED/TIMEOUT: host_start restarts exactly as from IDLE.
- host_start in LOAD/RELEASE/RUN is ignored.
- host_abort in any non-IDLE state -> IDLE next cycle, cpu_reset_n=0. Abort beats start, halt and the final transfer when simultaneous (a final transfer on the abort cycle is still written, but the sequence ends in IDLE).
- reset mid-load or mid-run: immediate IDLE; partial image remains in memory; load_count cleared.
- Outside LOAD and RUN/HALTED: mem_wr=0 always. The CPU can never write while loader owns the bus, and vice versa.
- run_cnt is 16 bits; it does not wrap because RUN exits at MAX_RUN-1.

Test Plan:
- reset, host_len=3, host_start, words 0x21,0x45,0xE0 with host_valid continuous -> mem_wr high 3 cycles at addr 0,1,2; RELEASE 1 cycle; cpu_reset_n rises 5 cycles after start; load_count=3.
- host_valid toggled 1,0,0,1,1 for 3 words -> writes only on valid cycles, addresses stay contiguous 0..2, host_ready drops after the third write.
- RUN with cpu_halt asserted on 4th RUN cycle -> done=1, busy=0, cpu_reset_n stays 1; CPU writes (cpu_mem_wr=1, addr 0x1F, data 0x7A) in RUN appear on mem_* same cycle.
- MAX_RUN=8, cpu_halt never asserted -> TIMEOUT after 8 RUN cycles, cpu_reset_n=0, timeout=1; cpu_halt and limit coincident -> HALTED instead.
- host_len=0 from HALTED -> no writes, RELEASE then RUN; host_start during RUN ignored; host_abort during LOAD after 2 words -> IDLE, load_count reflects 2 until next start.
- reset asserted mid-LOAD (word 2 of 4) -> next cycle IDLE, all outputs at reset values; new start with host_len=40 clamps to 32 writes.
